line_fill_server: RTL

Memory-side responder for the L1 cache line-fill protocol: accepts a line read request (strobe + address) from an I-cache refill port, fetches the 8 words of the aligned 256-bit line from a 32-bit word memory port with request/grant/rvalid handshaking, and returns the whole line with a one-cycle ready pulse. It sits between the cache's memory port and the word-wide memory/interconnect. Reads are pipelined up to a bounded number of outstanding word reads.

---
 rtl/line_fill_server_if.sv | 27 ++
 rtl/line_fill_server.sv | 76 +++++++
 2 files changed

// File: rtl/line_fill_server_if.sv
// Cache refill port and word-memory port of the line fill server, grouped as one bundle.
// The slave modport is the server's view of the bundle; the master modport is the view of the cache and memory side.
interface line_fill_server_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 256
);
  logic                  c_strobe_i;
  logic [ADDR_WIDTH-1:0] c_addr_i;
  logic                  c_ready_o;
  logic [LINE_SIZE-1:0]  c_data_o;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  c_strobe_i, c_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output c_ready_o, c_data_o, mem_req_o, mem_addr_o
  );

  modport master (
    output c_strobe_i, c_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  c_ready_o, c_data_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/line_fill_server.sv
// Fetches an aligned 8-word line over a req/gnt/rvalid word port and returns it with a one-cycle ready pulse.
// Ready comes 10 cycles after the strobe with an ideal memory; grant stalls and the outstanding-read cap delay it.
module line_fill_server #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_SIZE       = 256,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  line_fill_server_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, RESP, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [3:0]            issue_cnt_q, recv_cnt_q;
  logic [LINE_SIZE-1:0]  line_q;
  logic [3:0]            in_flight;
  logic                  issue_ok, grant, accept;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.c_addr_i[4:0];

  assign in_flight = issue_cnt_q - recv_cnt_q;
  assign issue_ok  = (state_q == FETCH) && (issue_cnt_q < 4'd8) &&
                     (in_flight < 4'(MAX_OUTSTANDING));
  assign grant     = issue_ok && bus.mem_gnt_i;
  // Only responses to reads actually granted in this fill are taken.
  assign accept    = (state_q == FETCH) && (in_flight != 4'd0) && bus.mem_rvalid_i;

  assign bus.mem_req_o  = issue_ok;
  assign bus.mem_addr_o = (state_q == FETCH) ?
                          base_q + ADDR_WIDTH'({issue_cnt_q, 2'b00}) : '0;
  assign bus.c_ready_o  = (state_q == RESP);
  assign bus.c_data_o   = line_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.c_strobe_i) state_d = FETCH;
      FETCH:   if (accept && recv_cnt_q == 4'd7) state_d = RESP;
      RESP:    state_d = RELEASE;
      RELEASE: if (!bus.c_strobe_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      line_q      <= '0;
    end else if (state_q == IDLE && bus.c_strobe_i) begin
      base_q      <= {bus.c_addr_i[ADDR_WIDTH-1:5], 5'b0};
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      if (grant) issue_cnt_q <= issue_cnt_q + 4'd1;
      if (accept) begin
        recv_cnt_q <= recv_cnt_q + 4'd1;
        // Word 0 lands in the most significant slot of the line.
        for (int k = 0; k < 8; k++) begin
          if (recv_cnt_q == 4'(k))
            line_q[LINE_SIZE-1-DATA_WIDTH*k -: DATA_WIDTH] <= bus.mem_rdata_i;
        end
      end
    end
  end
endmodule
